ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
- Parametrised next-generation PS/2 keyboard receiver. Adds input glitch filtering, start/parity/stop validation and a frame timeout.
- Decodes E0 (extended) and F0 (break) prefixes and buffers complete key events in a first-word-fall-through (FWFT) FIFO.
- Sits between the PS/2 connector pins and the keyboard/display logic. Consumers pop events at their own pace instead of catching a one-cycle flag.

Parameters:
- FILTER_LEN, 8: consecutive identical samples required before the filtered ps2_sclk changes state. Range 2..255.
- TIMEOUT_CYCLES, 50000: sys_clk cycles allowed between falling edges inside a frame before the frame is aborted.
- FIFO_DEPTH, 16: event FIFO depth. Power of 2, minimum 2.
- PARITY_CHECK, 1: 1 enables odd-parity checking; 0 ignores the parity bit.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- ps2_sclk  in  1  PS/2 clock, asynchronous to sys_clk
- ps2_sda  in  1  PS/2 data, asynchronous to sys_clk
- rd_en  in  1  pop the head entry; ignored when rec_valid=0
- rec_data  out  16  FIFO head: {3'b0, ext, 3'b0, brk, code[7:0]}
- rec_valid  out  1  FIFO not empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of stored entries
- parity_err  out  1  one-cycle pulse: frame had bad parity
- frame_err  out  1  one-cycle pulse: bad stop bit or timeout
- overflow  out  1  sticky: an event was dropped because the FIFO was full; cleared only by reset

Behaviour:
- Reset: all outputs 0, rec_data=16'h0000; FSM in IDLE; prefix flags cleared; FIFO empty; filtered sclk=1.
- Input synchronisation: ps2_sclk and ps2_sda each pass through 2-flop synchronisers.
- Clock filter: filtered sclk takes the synchronised value once it has been stable for FILTER_LEN consecutive cycles.
- Edge detection: a falling edge of the filtered sclk produces a one-cycle pulse fe. The synchronised sda is sampled in the fe cycle.
- Frame FSM (states IDLE, DATA, PARITY, STOP), acting on fe only:
  - IDLE: sda=0 -> DATA with bit counter=0. sda=1 -> stay in IDLE (stray edge, no error).
  - DATA: shift sda in LSB first; after the 8th bit go to PARITY.
  - PARITY: latch the parity bit; go to STOP.
  - STOP: always return to IDLE.
    - sda=1 and parity ok -> byte_done for one cycle.
    - sda=0 -> frame_err.
    - sda=1 but parity bad with PARITY_CHECK=1 -> parity_err only.
  - Parity ok means the XOR of the 8 data bits and the parity bit equals 1.
  - If both stop and parity are bad, frame_err only is raised.
- Timeout: the counter clears on every fe and while in IDLE.
  - Outside IDLE, when the counter reaches TIMEOUT_CYCLES-1: frame_err pulse, return to IDLE, discard partial byte.
  - The next fe is then treated as a start bit.
- Decode, in the cycle after byte_done:
  - E0 -> set ext; no push.
  - F0 -> set brk; no push.
  - Any other code -> push {ext,brk,code}, then clear ext and brk.
  - Any parity_err or frame_err clears ext and brk.
- Latency: stop-bit fe in cycle N -> push in N+1 -> rec_valid and rec_data valid from N+2.
- FIFO is FWFT: rec_data always shows the head entry. rd_en with rec_valid=1 advances the head at the clock edge.
- FIFO boundary cases:
  - Push and pop in the same cycle: both performed; count unchanged. This holds when full (push accepted) and when count=1.
  - Push while full with no pop: entry dropped, overflow set, count stays FIFO_DEPTH.
  - Pop while empty: no effect; count stays 0.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-frame or mid-FIFO: everything returns to reset values immediately (asynchronous). The first frame after reset release begins on the next valid start bit.

Test Plan:
- Frame 1C with parity 0 and stop 1, rd_en=0 -> rec_valid=1 at N+2, rec_data=16'h001C, fifo_count=1.
- Frames E0, F0, 75 -> single entry 16'h1175. Next frame 1C -> 16'h001C (flags cleared).
- Frame 1C with parity 1, PARITY_CHECK=1 -> parity_err pulse, no push. Following E0 then 6B -> 16'h106B.
- Sclk glitch low for FILTER_LEN-1 cycles in IDLE -> no fe, FSM stays IDLE. Start bit then 4 bits, then idle TIMEOUT_CYCLES -> frame_err; next full frame 29 -> 16'h0029.
- FIFO_DEPTH+1 frames (codes 01..11), no reads -> fifo_count=16, overflow=1, head 16'h0001. Pop all 16 -> last entry 16'h0010, rec_valid=0.
- FIFO full with rd_en high in the push cycle -> push accepted, count stays 16, overflow stays 0. sys_rst pulse during DATA -> all outputs 0.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronises and glitch-filters the pins, checks start/parity/stop,
// aborts stalled frames, folds E0/F0 prefixes into key events and queues them in a FWFT FIFO.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 16,
    parameter bit PARITY_CHECK   = 1'b1
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          ps2_sclk,
    input  logic                          ps2_sda,
    input  logic                          rd_en,
    output logic [15:0]                   rec_data,
    output logic                          rec_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Handshake: rd_en is a pop request, honoured only while rec_valid=1; rec_data is the
    // current head and is replaced by the next entry on the clock edge that accepts the pop.

    logic            sclk_s1_q, sclk_s2_q, sda_s1_q, sda_s2_q;
    logic [7:0]      filt_cnt_q;
    logic            sclk_filt_q, sclk_prev_q;
    logic            fe;

    state_t          state_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            byte_done_q, parity_err_q, frame_err_q;

    logic            ext_q, brk_q;
    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]  count_q;
    logic            overflow_q;
    logic            push_req, do_push, do_pop, full;
    logic [9:0]      head;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sclk_s1_q   <= 1'b1;
            sclk_s2_q   <= 1'b1;
            sda_s1_q    <= 1'b1;
            sda_s2_q    <= 1'b1;
            filt_cnt_q  <= '0;
            sclk_filt_q <= 1'b1;
            sclk_prev_q <= 1'b1;
        end else begin
            sclk_s1_q   <= ps2_sclk;
            sclk_s2_q   <= sclk_s1_q;
            sda_s1_q    <= ps2_sda;
            sda_s2_q    <= sda_s1_q;
            sclk_prev_q <= sclk_filt_q;
            // The filtered clock flips after FILTER_LEN consecutive samples disagreeing with it.
            if (sclk_s2_q == sclk_filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == 8'(FILTER_LEN - 1)) begin
                filt_cnt_q  <= '0;
                sclk_filt_q <= sclk_s2_q;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    assign fe = sclk_prev_q & ~sclk_filt_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            byte_done_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_done_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (fe || state_q == IDLE) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (fe) begin
                case (state_q)
                    IDLE: begin
                        if (!sda_s2_q) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {sda_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_q   <= sda_s2_q;
                        state_q <= STOP;
                    end
                    default: begin
                        state_q <= IDLE;
                        // A bad stop bit outranks a bad parity bit.
                        if (!sda_s2_q) begin
                            frame_err_q <= 1'b1;
                        end else if (PARITY_CHECK && !(^shift_q ^ par_q)) begin
                            parity_err_q <= 1'b1;
                        end else begin
                            byte_done_q <= 1'b1;
                        end
                    end
                endcase
            end else if (state_q != IDLE && to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                frame_err_q <= 1'b1;
                state_q     <= IDLE;
                bit_cnt_q   <= '0;
                shift_q     <= '0;
            end
        end
    end

    assign push_req = byte_done_q && (shift_q != 8'hE0) && (shift_q != 8'hF0);
    assign full     = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign do_pop   = rd_en && (count_q != '0);
    assign do_push  = push_req && (!full || do_pop);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (parity_err_q || frame_err_q) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (byte_done_q) begin
                if (shift_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end
            if (push_req && !do_push) begin
                overflow_q <= 1'b1;
            end
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {ext_q, brk_q, shift_q};
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign head       = (count_q != '0) ? mem_q[rd_ptr_q] : 10'd0;
    assign rec_data   = {3'b000, head[9], 3'b000, head[8], head[7:0]};
    assign rec_valid  = (count_q != '0);
    assign fifo_count = count_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: bit-banged PS/2 frames, hand-computed key events in an
// expected queue, error-pulse counters and FIFO boundary cases.
module tb_ps2_rx_fifo;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 300;
    localparam int DEPTH      = 16;
    localparam int HALF       = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b1;
    logic        sda = 1'b1;
    logic        rd_en = 1'b0;
    logic [15:0] rec_data;
    logic        rec_valid;
    logic [4:0]  fifo_count;
    logic        parity_err, frame_err, overflow;

    logic [15:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int pe_cnt = 0;
    int fe_cnt = 0;

    ps2_rx_fifo #(
        .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT),
        .FIFO_DEPTH(DEPTH), .PARITY_CHECK(1'b1)
    ) dut (
        .sys_clk(clk), .sys_rst(rst), .ps2_sclk(sclk), .ps2_sda(sda), .rd_en(rd_en),
        .rec_data(rec_data), .rec_valid(rec_valid), .fifo_count(fifo_count),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (parity_err) pe_cnt++;
        if (frame_err) fe_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sda = b;
        tick(HALF);
        sclk = 1'b0;
        tick(HALF);
        sclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit((~^code) ^ bad_par);
        send_bit(stop);
        sda = 1'b1;
        tick(HALF);
    endtask

    task automatic pop_one(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_exp_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, {31'd0, rec_valid}, 32'd1);
            check({tag, "_data"}, {16'd0, rec_data}, {16'd0, e});
        end
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(3);
        exp_q.delete();
    endtask

    initial begin
        tick(3);
        check("rst_valid", {31'd0, rec_valid}, 32'd0);
        check("rst_data", {16'd0, rec_data}, 32'd0);
        check("rst_count", {27'd0, fifo_count}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_perr", {31'd0, parity_err}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        tick(HALF);

        // Frame 1C, stop bit driven by hand to check the N+2 latency.
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(8'h1C >> i);
        send_bit(1'b0);
        sda = 1'b1;
        tick(HALF);
        sclk = 1'b0;
        tick(FILTER_LEN + 3);
        check("lat_before", {31'd0, rec_valid}, 32'd0);
        tick(1);
        check("lat_valid", {31'd0, rec_valid}, 32'd1);
        check("lat_data", {16'd0, rec_data}, 32'h001C);
        check("lat_count", {27'd0, fifo_count}, 32'd1);
        tick(HALF - FILTER_LEN - 4);
        sclk = 1'b1;
        tick(HALF);
        exp_q.push_back(16'h001C);
        pop_one("f1c");
        check("f1c_count_after", {27'd0, fifo_count}, 32'd0);

        // Prefixes fold into one event and are cleared afterwards.
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        check("pref_count1", {27'd0, fifo_count}, 32'd1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("pref_count2", {27'd0, fifo_count}, 32'd2);
        exp_q.push_back(16'h1175);
        exp_q.push_back(16'h001C);
        pop_one("pref_a");
        pop_one("pref_b");

        // Bad parity: pulse, no push; then E0 6B.
        send_frame(8'h1C, 1'b1, 1'b1);
        check("par_pulses", pe_cnt, 32'd1);
        check("par_nopush", {27'd0, fifo_count}, 32'd0);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h6B, 1'b0, 1'b1);
        exp_q.push_back(16'h106B);
        pop_one("ext6b");

        // Short sclk glitch with sda low must not start a frame.
        sda = 1'b0;
        tick(5);
        sclk = 1'b0;
        tick(FILTER_LEN - 1);
        sclk = 1'b1;
        tick(HALF);
        sda = 1'b1;
        tick(HALF);
        send_frame(8'h29, 1'b0, 1'b1);
        check("glitch_ferr", fe_cnt, 32'd0);
        exp_q.push_back(16'h0029);
        pop_one("glitch29");

        // Partial frame then silence: timeout.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        tick(TIMEOUT + 100);
        check("to_ferr", fe_cnt, 32'd1);
        check("to_nopush", {27'd0, fifo_count}, 32'd0);
        send_frame(8'h29, 1'b0, 1'b1);
        exp_q.push_back(16'h0029);
        pop_one("to29");

        // Fill past depth.
        for (int c = 1; c <= DEPTH; c++) begin
            send_frame(8'(c), 1'b0, 1'b1);
            exp_q.push_back(16'(c));
        end
        check("fill_count", {27'd0, fifo_count}, 32'd16);
        check("fill_ovf0", {31'd0, overflow}, 32'd0);
        send_frame(8'h11, 1'b0, 1'b1);
        check("ovf_count", {27'd0, fifo_count}, 32'd16);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_head", {16'd0, rec_data}, 32'h0001);
        for (int i = 0; i < DEPTH; i++) pop_one("drain");
        check("drain_valid", {31'd0, rec_valid}, 32'd0);
        check("drain_count", {27'd0, fifo_count}, 32'd0);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("empty_pop", {27'd0, fifo_count}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Full FIFO with a pop in the push cycle.
        do_reset();
        for (int c = 1; c <= DEPTH; c++) begin
            send_frame(8'(c), 1'b0, 1'b1);
            exp_q.push_back(16'(c));
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(8'h11 >> i);
        send_bit(1'b1);
        sda = 1'b1;
        tick(HALF);
        sclk = 1'b0;
        tick(FILTER_LEN + 3);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(16'h0011);
        check("fullpp_count", {27'd0, fifo_count}, 32'd16);
        check("fullpp_ovf", {31'd0, overflow}, 32'd0);
        check("fullpp_head", {16'd0, rec_data}, 32'h0002);
        tick(HALF - FILTER_LEN - 4);
        sclk = 1'b1;
        tick(HALF);

        // Asynchronous reset in the middle of a frame.
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, rec_valid}, 32'd0);
        check("arst_count", {27'd0, fifo_count}, 32'd0);
        check("arst_data", {16'd0, rec_data}, 32'd0);
        check("arst_ovf", {31'd0, overflow}, 32'd0);
        tick(2);
        rst = 1'b0;
        exp_q.delete();
        tick(HALF);
        send_frame(8'h5A, 1'b0, 1'b1);
        check("post_rst_count", {27'd0, fifo_count}, 32'd1);
        exp_q.push_back(16'h005A);
        pop_one("post5a");

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
